// File: rtl/memory_sub_system_param.sv
// Shared parameters and types for the memory sub-system.
// Holds the cache geometry defaults and the cache controller state encoding.
package memory_sub_system_param;

    localparam int unsigned INDEX_LENGTH  = 4;
    localparam int unsigned TAG_LENGTH    = 4;
    localparam int unsigned OFFSET_LENGTH = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        COMPARE,
        REFILL,
        UPDATE,
        WRITE_MEM
    } cache_state_t;

endpackage

// File: rtl/dm_cache_refill.sv
// Line refill engine: word counter plus main-memory read handshake.
// Each acked word is written to the data array; done flags the final word.
module dm_cache_refill
    import memory_sub_system_param::*;
#(
    parameter int unsigned OFFSET_LEN = OFFSET_LENGTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  active_i,
    input  logic                  mem_ack_i,
    output logic [OFFSET_LEN-1:0] word_cnt_o,
    output logic                  word_we_o,
    output logic                  done_o
);

    logic [OFFSET_LEN-1:0] cnt_q;

    // An ack only counts while the refill owns the memory request.
    assign word_we_o  = active_i & mem_ack_i;
    assign done_o     = word_we_o & (&cnt_q);
    assign word_cnt_o = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (start_i) begin
            cnt_q <= '0;
        end else if (word_we_o) begin
            cnt_q <= cnt_q + OFFSET_LEN'(1);
        end
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped cache controller: lookup, line refill on read miss,
// write-through / no-write-allocate writes to main memory.
module dm_cache_ctrl
    import memory_sub_system_param::*;
#(
    parameter int unsigned INDEX_LEN  = INDEX_LENGTH,
    parameter int unsigned TAG_LEN    = TAG_LENGTH,
    parameter int unsigned OFFSET_LEN = OFFSET_LENGTH,
    parameter int unsigned DATA_W     = 32,
    localparam int unsigned ADDR_LEN  = TAG_LEN + INDEX_LEN + OFFSET_LEN
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_LEN-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_hit,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic [INDEX_LEN-1:0]  line_index,
    output logic [OFFSET_LEN-1:0] line_offset,
    output logic                  valid_write,
    input  logic                  valid_in,
    output logic                  tag_write,
    output logic [TAG_LEN-1:0]    tag_wdata,
    input  logic [TAG_LEN-1:0]    tag_rdata,
    output logic                  data_write,
    output logic [DATA_W-1:0]     data_wdata,
    input  logic [DATA_W-1:0]     data_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_LEN-1:0]   mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
);

    cache_state_t          state_q;
    logic [ADDR_LEN-1:0]   addr_q;
    logic                  we_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  miss_q;
    logic                  hit_q;

    logic [TAG_LEN-1:0]    tag_f;
    logic [INDEX_LEN-1:0]  index_f;
    logic [OFFSET_LEN-1:0] offset_f;
    logic                  lookup_hit;

    logic                  refill_start;
    logic                  refill_active;
    logic [OFFSET_LEN-1:0] refill_cnt;
    logic                  refill_we;
    logic                  refill_done;

    assign tag_f      = addr_q[ADDR_LEN-1 -: TAG_LEN];
    assign index_f    = addr_q[OFFSET_LEN +: INDEX_LEN];
    assign offset_f   = addr_q[OFFSET_LEN-1:0];
    assign lookup_hit = valid_in & (tag_rdata == tag_f);

    assign refill_start  = (state_q == COMPARE) & ~we_q & ~lookup_hit;
    assign refill_active = (state_q == REFILL);

    dm_cache_refill #(
        .OFFSET_LEN (OFFSET_LEN)
    ) u_refill (
        .clk        (clk),
        .rst_n      (resetn),
        .start_i    (refill_start),
        .active_i   (refill_active),
        .mem_ack_i  (mem_ack),
        .word_cnt_o (refill_cnt),
        .word_we_o  (refill_we),
        .done_o     (refill_done)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            miss_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                        miss_q  <= 1'b0;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: state_q <= COMPARE;
                COMPARE: begin
                    hit_q <= lookup_hit;
                    if (we_q) begin
                        state_q <= WRITE_MEM;
                    end else if (lookup_hit) begin
                        state_q <= IDLE;
                    end else begin
                        miss_q  <= 1'b1;
                        state_q <= REFILL;
                    end
                end
                REFILL: begin
                    if (refill_done) state_q <= UPDATE;
                end
                // Replay the lookup so the read completes through the normal hit path.
                UPDATE: state_q <= LOOKUP;
                WRITE_MEM: begin
                    if (mem_ack) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        cpu_ready   = 1'b0;
        cpu_hit     = 1'b0;
        cpu_rdata   = '0;
        line_index  = index_f;
        line_offset = offset_f;
        valid_write = 1'b0;
        tag_write   = 1'b0;
        tag_wdata   = '0;
        data_write  = 1'b0;
        data_wdata  = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state_q)
            COMPARE: begin
                if (lookup_hit && !we_q) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = data_rdata;
                    cpu_hit   = ~miss_q;
                end
                if (lookup_hit && we_q) begin
                    data_write = 1'b1;
                    data_wdata = wdata_q;
                end
            end
            REFILL: begin
                mem_req     = 1'b1;
                mem_addr    = {tag_f, index_f, refill_cnt};
                line_offset = refill_cnt;
                data_write  = refill_we;
                data_wdata  = refill_we ? mem_rdata : '0;
            end
            UPDATE: begin
                valid_write = 1'b1;
                tag_write   = 1'b1;
                tag_wdata   = tag_f;
            end
            WRITE_MEM: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ack) begin
                    cpu_ready = 1'b1;
                    cpu_hit   = hit_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl with behavioural valid/tag/data arrays
// and a main-memory responder with programmable ack delay.
module tb_dm_cache_ctrl;
    import memory_sub_system_param::*;

    localparam int IL = 4;
    localparam int TL = 4;
    localparam int OL = 2;
    localparam int DW = 32;
    localparam int AL = TL + IL + OL;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cpu_req;
    logic          cpu_we;
    logic [AL-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic          cpu_hit;
    logic [DW-1:0] cpu_rdata;
    logic [IL-1:0] line_index;
    logic [OL-1:0] line_offset;
    logic          valid_write;
    logic          valid_in;
    logic          tag_write;
    logic [TL-1:0] tag_wdata;
    logic [TL-1:0] tag_rdata;
    logic          data_write;
    logic [DW-1:0] data_wdata;
    logic [DW-1:0] data_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AL-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int passes = 0;

    dm_cache_ctrl #(
        .INDEX_LEN  (IL),
        .TAG_LEN    (TL),
        .OFFSET_LEN (OL),
        .DATA_W     (DW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ready   (cpu_ready),
        .cpu_hit     (cpu_hit),
        .cpu_rdata   (cpu_rdata),
        .line_index  (line_index),
        .line_offset (line_offset),
        .valid_write (valid_write),
        .valid_in    (valid_in),
        .tag_write   (tag_write),
        .tag_wdata   (tag_wdata),
        .tag_rdata   (tag_rdata),
        .data_write  (data_write),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Cache arrays with one-cycle registered reads.
    logic          valid_arr [16] = '{default: 1'b0};
    logic [TL-1:0] tag_arr   [16] = '{default: '0};
    logic [DW-1:0] data_arr  [64] = '{default: '0};

    always @(posedge clk) begin
        valid_in   <= valid_arr[line_index];
        tag_rdata  <= tag_arr[line_index];
        data_rdata <= data_arr[{line_index, line_offset}];
        if (valid_write) valid_arr[line_index] <= 1'b1;
        if (tag_write)   tag_arr[line_index]   <= tag_wdata;
        if (data_write)  data_arr[{line_index, line_offset}] <= data_wdata;
    end

    // Main memory: line 0x29 holds 0x11..0x44, every other word is 0xC0000000|addr.
    function automatic logic [DW-1:0] mem_word(input logic [AL-1:0] a);
        if (a[AL-1:OL] == 8'h29) begin
            case (a[1:0])
                2'd0:    return 32'h11;
                2'd1:    return 32'h22;
                2'd2:    return 32'h33;
                default: return 32'h44;
            endcase
        end
        return 32'hC000_0000 | {22'd0, a};
    endfunction

    int unsigned ack_delay = 0;
    int unsigned wait_cnt  = 0;
    logic        force_ack = 1'b0;

    assign mem_ack   = (mem_req && (wait_cnt >= ack_delay)) || force_ack;
    assign mem_rdata = mem_word(mem_addr);

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    // Cumulative activity monitor; tests take differences around each request.
    int            dw_cnt   = 0;
    int            vw_cnt   = 0;
    int            tw_cnt   = 0;
    int            mreq_cyc = 0;
    int            mwe_cyc  = 0;
    int            mwr_cnt  = 0;
    logic [7:0]    dw_seq   = '0;
    logic [DW-1:0] dw_last  = '0;
    logic [TL-1:0] tw_last  = '0;
    logic [AL-1:0] mw_addr  = '0;
    logic [DW-1:0] mw_data  = '0;

    always @(negedge clk) begin
        if (data_write) begin
            dw_cnt  = dw_cnt + 1;
            dw_seq  = {dw_seq[5:0], line_offset};
            dw_last = data_wdata;
        end
        if (valid_write) vw_cnt = vw_cnt + 1;
        if (tag_write) begin
            tw_cnt  = tw_cnt + 1;
            tw_last = tag_wdata;
        end
        if (mem_req) mreq_cyc = mreq_cyc + 1;
        if (mem_req && mem_we) mwe_cyc = mwe_cyc + 1;
        if (mem_req && mem_ack && mem_we) begin
            mwr_cnt = mwr_cnt + 1;
            mw_addr = mem_addr;
            mw_data = mem_wdata;
        end
    end

    // lat counts cycles after the accepting edge until cpu_ready is seen.
    task automatic do_req(input logic [AL-1:0] a, input logic we, input logic [DW-1:0] wd,
                          output int lat, output logic [DW-1:0] rd, output logic hit,
                          output logic done);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        done = 1'b0; lat = -1; rd = '0; hit = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (cpu_ready) begin
                done = 1'b1; lat = c; rd = cpu_rdata; hit = cpu_hit;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (dut.state_q !== IDLE) $display("FAIL reset_state got %0d want IDLE", dut.state_q); else passes++;
        checks++; if ({cpu_ready, cpu_hit, mem_req, mem_we, valid_write, tag_write, data_write} !== 7'b0)
            $display("FAIL reset_ctrl_outputs got %b want 0", {cpu_ready, cpu_hit, mem_req, mem_we, valid_write, tag_write, data_write}); else passes++;
        checks++; if ({line_index, line_offset, mem_addr} !== '0)
            $display("FAIL reset_addr_outputs got %h want 0", {line_index, line_offset, mem_addr}); else passes++;
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_read_miss();
        int lat; logic [DW-1:0] rd; logic hit, done;
        int dw0, vw0, tw0, mr0, mw0;
        dw0 = dw_cnt; vw0 = vw_cnt; tw0 = tw_cnt; mr0 = mreq_cyc; mw0 = mwe_cyc;
        do_req(10'h0A5, 1'b0, '0, lat, rd, hit, done);
        checks++; if (done !== 1'b1) $display("FAIL miss_done got %b want 1", done); else passes++;
        checks++; if (lat !== 9) $display("FAIL miss_latency got %0d want 9", lat); else passes++;
        checks++; if (rd !== 32'h22) $display("FAIL miss_rdata got %h want 22", rd); else passes++;
        checks++; if (hit !== 1'b0) $display("FAIL miss_hit got %b want 0", hit); else passes++;
        checks++; if (dw_cnt - dw0 !== 4) $display("FAIL miss_data_writes got %0d want 4", dw_cnt - dw0); else passes++;
        checks++; if (dw_seq !== 8'h1B) $display("FAIL miss_offset_order got %h want 1b", dw_seq); else passes++;
        checks++; if (vw_cnt - vw0 !== 1) $display("FAIL miss_valid_writes got %0d want 1", vw_cnt - vw0); else passes++;
        checks++; if (tw_cnt - tw0 !== 1) $display("FAIL miss_tag_writes got %0d want 1", tw_cnt - tw0); else passes++;
        checks++; if (tw_last !== 4'h2) $display("FAIL miss_tag_wdata got %h want 2", tw_last); else passes++;
        checks++; if (mreq_cyc - mr0 !== 4) $display("FAIL miss_mem_req_cycles got %0d want 4", mreq_cyc - mr0); else passes++;
        checks++; if (mwe_cyc - mw0 !== 0) $display("FAIL miss_mem_we_cycles got %0d want 0", mwe_cyc - mw0); else passes++;
        checks++; if ({data_arr[36], data_arr[37], data_arr[38], data_arr[39]} !== {32'h11, 32'h22, 32'h33, 32'h44})
            $display("FAIL miss_line_contents got %h %h %h %h want 11 22 33 44",
                     data_arr[36], data_arr[37], data_arr[38], data_arr[39]); else passes++;
    endtask

    task automatic test_read_hit();
        int lat; logic [DW-1:0] rd; logic hit, done;
        int mr0;
        mr0 = mreq_cyc;
        do_req(10'h0A7, 1'b0, '0, lat, rd, hit, done);
        checks++; if (lat !== 2) $display("FAIL hit_latency got %0d want 2", lat); else passes++;
        checks++; if (rd !== 32'h44) $display("FAIL hit_rdata got %h want 44", rd); else passes++;
        checks++; if (hit !== 1'b1) $display("FAIL hit_flag got %b want 1", hit); else passes++;
        checks++; if (mreq_cyc - mr0 !== 0) $display("FAIL hit_mem_req_cycles got %0d want 0", mreq_cyc - mr0); else passes++;
    endtask

    task automatic test_write_hit();
        int lat; logic [DW-1:0] rd; logic hit, done;
        int dw0, mr0, mw0, wr0;
        dw0 = dw_cnt; mr0 = mreq_cyc; mw0 = mwe_cyc; wr0 = mwr_cnt;
        ack_delay = 3;
        do_req(10'h0A4, 1'b1, 32'hDEAD, lat, rd, hit, done);
        ack_delay = 0;
        checks++; if (lat !== 6) $display("FAIL wrhit_latency got %0d want 6", lat); else passes++;
        checks++; if (hit !== 1'b1) $display("FAIL wrhit_flag got %b want 1", hit); else passes++;
        checks++; if (dw_cnt - dw0 !== 1) $display("FAIL wrhit_data_writes got %0d want 1", dw_cnt - dw0); else passes++;
        checks++; if ({dw_seq[1:0], dw_last} !== {2'd0, 32'hDEAD}) $display("FAIL wrhit_array_write got %0d/%h want 0/dead", dw_seq[1:0], dw_last); else passes++;
        checks++; if (mreq_cyc - mr0 !== 4) $display("FAIL wrhit_mem_req_cycles got %0d want 4", mreq_cyc - mr0); else passes++;
        checks++; if (mwe_cyc - mw0 !== 4) $display("FAIL wrhit_mem_we_cycles got %0d want 4", mwe_cyc - mw0); else passes++;
        checks++; if (mwr_cnt - wr0 !== 1) $display("FAIL wrhit_mem_writes got %0d want 1", mwr_cnt - wr0); else passes++;
        checks++; if ({mw_addr, mw_data} !== {10'h0A4, 32'hDEAD}) $display("FAIL wrhit_mem_xfer got %h/%h want 0a4/dead", mw_addr, mw_data); else passes++;
        do_req(10'h0A4, 1'b0, '0, lat, rd, hit, done);
        checks++; if ({rd, hit} !== {32'hDEAD, 1'b1}) $display("FAIL wrhit_readback got %h/%b want dead/1", rd, hit); else passes++;
    endtask

    task automatic test_write_miss();
        int lat; logic [DW-1:0] rd; logic hit, done;
        int dw0, vw0, wr0;
        dw0 = dw_cnt; vw0 = vw_cnt; wr0 = mwr_cnt;
        do_req(10'h1A4, 1'b1, 32'hBEEF, lat, rd, hit, done);
        checks++; if (lat !== 3) $display("FAIL wrmiss_latency got %0d want 3", lat); else passes++;
        checks++; if (hit !== 1'b0) $display("FAIL wrmiss_flag got %b want 0", hit); else passes++;
        checks++; if (dw_cnt - dw0 !== 0) $display("FAIL wrmiss_data_writes got %0d want 0", dw_cnt - dw0); else passes++;
        checks++; if (vw_cnt - vw0 !== 0) $display("FAIL wrmiss_valid_writes got %0d want 0", vw_cnt - vw0); else passes++;
        checks++; if (mwr_cnt - wr0 !== 1) $display("FAIL wrmiss_mem_writes got %0d want 1", mwr_cnt - wr0); else passes++;
        checks++; if ({mw_addr, mw_data} !== {10'h1A4, 32'hBEEF}) $display("FAIL wrmiss_mem_xfer got %h/%h want 1a4/beef", mw_addr, mw_data); else passes++;
        checks++; if (data_arr[36] !== 32'hDEAD) $display("FAIL wrmiss_line_untouched got %h want dead", data_arr[36]); else passes++;
    endtask

    task automatic test_reset_mid_refill();
        int lat; logic [DW-1:0] rd; logic hit, done;
        int acks, dw0, vw0;
        acks = 0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h0C1; cpu_wdata = '0;
        for (int c = 0; c < 50 && acks < 2; c++) begin
            @(negedge clk);
            if (data_write) acks++;
        end
        checks++; if (acks !== 2) $display("FAIL rstmid_reached_acks got %0d want 2", acks); else passes++;
        @(posedge clk); #1;
        resetn = 1'b0; cpu_req = 1'b0;
        #1;
        checks++; if (dut.state_q !== IDLE) $display("FAIL rstmid_state got %0d want IDLE", dut.state_q); else passes++;
        checks++; if ({cpu_ready, mem_req, mem_we, valid_write, tag_write, data_write} !== 6'b0)
            $display("FAIL rstmid_ctrl_outputs got %b want 0", {cpu_ready, mem_req, mem_we, valid_write, tag_write, data_write}); else passes++;
        checks++; if ({line_index, line_offset, mem_addr, data_wdata} !== '0)
            $display("FAIL rstmid_data_outputs got %h want 0", {line_index, line_offset, mem_addr, data_wdata}); else passes++;
        @(posedge clk); #1;
        resetn = 1'b1;
        checks++; if (valid_arr[0] !== 1'b0) $display("FAIL rstmid_valid_set got %b want 0", valid_arr[0]); else passes++;
        dw0 = dw_cnt; vw0 = vw_cnt;
        do_req(10'h0C1, 1'b0, '0, lat, rd, hit, done);
        checks++; if (dw_cnt - dw0 !== 4) $display("FAIL rstmid_refill_words got %0d want 4", dw_cnt - dw0); else passes++;
        checks++; if (vw_cnt - vw0 !== 1) $display("FAIL rstmid_valid_writes got %0d want 1", vw_cnt - vw0); else passes++;
        checks++; if ({lat, rd, hit} !== {32'd9, 32'hC000_00C1, 1'b0})
            $display("FAIL rstmid_reread got lat %0d data %h hit %b want 9 c00000c1 0", lat, rd, hit); else passes++;
    endtask

    task automatic test_idle_ack();
        int mr0;
        mr0 = mreq_cyc;
        @(posedge clk); #1;
        force_ack = 1'b1;
        @(negedge clk);
        checks++; if ({mem_req, cpu_ready, data_write} !== 3'b0) $display("FAIL idleack_outputs got %b want 0", {mem_req, cpu_ready, data_write}); else passes++;
        @(posedge clk); #1;
        force_ack = 1'b0;
        @(negedge clk);
        checks++; if (dut.state_q !== IDLE) $display("FAIL idleack_state got %0d want IDLE", dut.state_q); else passes++;
        checks++; if (mreq_cyc - mr0 !== 0) $display("FAIL idleack_mem_req_cycles got %0d want 0", mreq_cyc - mr0); else passes++;
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_write_miss();
        test_reset_mid_refill();
        test_idle_ack();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
